trapezoid_integral_acc: RTL and testbench

- Consumer end of the trapezoid surface stream: takes surf/valid pairs from the trapezoid surface calculator and sums a programmable window of consecutive surfaces into one integral.
- Presents the integral on a valid/ready output handshake and holds it until it is accepted.
- Sits between the surface calculator and the result readout (register bank / UART path).

---
 rtl/trapezoid_integral_acc.sv | 117 +++++++++++
 tb/tb_trapezoid_integral_acc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trapezoid_integral_acc.sv
// Sums a programmable window of trapezoid surfaces into one integral, held on a valid/ready port.
// Optional TRAPEZOID_SCALE_CORRECT_EN: register the integral as sum >> 4 (overflow still on raw sum).
module trapezoid_integral_acc #(
  parameter int SURF_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [SURF_W-1:0] surf_in,
  input  logic              surf_valid,
  output logic              busy,
  output logic [ACC_W-1:0]  integral,
  output logic              integral_valid,
  input  logic              integral_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_cnt
);

  // state | meaning
  // IDLE  | waiting for start
  // ACCUM | summing surfaces until len_q samples taken
  // HOLD  | integral presented until accepted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   integral_q, integral_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W:0]     sum_w;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   result_w;

  // Extra top bit of sum_w is the carry out of the wrapping accumulator.
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - SURF_W){1'b0}}, surf_in};
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef TRAPEZOID_SCALE_CORRECT_EN
  assign result_w = sum_w[ACC_W-1:0] >> 4;
`else
  assign result_w = sum_w[ACC_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    integral_d = integral_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = win_len;
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (win_len == '0) begin
            integral_d = '0;
            state_d    = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (surf_valid) begin
          acc_d = sum_w[ACC_W-1:0];
          ovf_d = ovf_q | sum_w[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            integral_d = result_w;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (integral_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      integral_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      integral_q <= integral_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign integral_valid = (state_q == HOLD);
  assign integral       = integral_q;
  assign overflow       = ovf_q;
  assign sample_cnt     = cnt_q;

endmodule

// File: tb/tb_trapezoid_integral_acc.sv
// Randomized and directed bench for trapezoid_integral_acc; two instances (ACC_W 48 and 33)
// share stimulus and are checked each cycle against a true-sum reference model.
module tb_trapezoid_integral_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic [31:0] surf_in = '0;
  logic        surf_valid = 1'b0;
  logic        rdy = 1'b0;

  logic        busy_a, valid_a, ovf_a;
  logic [47:0] int_a;
  logic [15:0] cnt_a;
  logic        busy_b, valid_b, ovf_b;
  logic [32:0] int_b;
  logic [15:0] cnt_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  trapezoid_integral_acc dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .surf_in(surf_in),
    .surf_valid(surf_valid), .busy(busy_a), .integral(int_a), .integral_valid(valid_a),
    .integral_ready(rdy), .overflow(ovf_a), .sample_cnt(cnt_a)
  );

  trapezoid_integral_acc #(.ACC_W(33)) dut33 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .surf_in(surf_in),
    .surf_valid(surf_valid), .busy(busy_b), .integral(int_b), .integral_valid(valid_b),
    .integral_ready(rdy), .overflow(ovf_b), .sample_cnt(cnt_b)
  );

  // Reference model: keeps the true (unbounded) window sum; wrap and overflow derived from it.
  bit          m_busy, m_valid;
  int unsigned m_len, m_cnt;
  logic [63:0] m_sum;
  logic [63:0] m_int [2];
  int          acc_w [2] = '{48, 33};

  function automatic logic [63:0] scaled(input logic [63:0] s, input int w);
    logic [63:0] r;
    r = s & ((64'd1 << w) - 64'd1);
`ifdef TRAPEZOID_SCALE_CORRECT_EN
    r = r >> 4;
`endif
    return r;
  endfunction

  function automatic bit m_ovf(input int w);
    return (m_sum >> w) != 64'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_len = 0; m_cnt = 0; m_sum = '0;
      m_int[0] = '0; m_int[1] = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_len = win_len; m_cnt = 0; m_sum = '0; m_busy = 1;
        if (win_len == 16'd0) begin
          m_valid = 1; m_int[0] = '0; m_int[1] = '0;
        end
      end
    end else if (!m_valid) begin
      if (surf_valid) begin
        m_sum = m_sum + {32'd0, surf_in};
        m_cnt = m_cnt + 1;
        if (m_cnt == m_len) begin
          m_valid = 1;
          for (int k = 0; k < 2; k++) m_int[k] = scaled(m_sum, acc_w[k]);
        end
      end
    end else if (rdy) begin
      m_busy = 0; m_valid = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy48",  64'(busy_a),  64'(m_busy));
      check("valid48", 64'(valid_a), 64'(m_valid));
      check("int48",   64'(int_a),   m_int[0]);
      check("ovf48",   64'(ovf_a),   64'(m_ovf(48)));
      check("cnt48",   64'(cnt_a),   64'(m_cnt));
      check("busy33",  64'(busy_b),  64'(m_busy));
      check("valid33", 64'(valid_b), 64'(m_valid));
      check("int33",   64'(int_b),   m_int[1]);
      check("ovf33",   64'(ovf_b),   64'(m_ovf(33)));
      check("cnt33",   64'(cnt_b),   64'(m_cnt));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1; win_len = l; cyc(); start = 1'b0;
  endtask

  task automatic send(input logic [31:0] s);
    surf_valid = 1'b1; surf_in = s; cyc(); surf_valid = 1'b0;
  endtask

  function automatic logic [63:0] sc(input logic [63:0] raw);
`ifdef TRAPEZOID_SCALE_CORRECT_EN
    return raw >> 4;
`else
    return raw;
`endif
  endfunction

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_int",  64'(int_a),  64'd0);

    // basic window
    rdy = 1'b1;
    do_start(16'd3);
    send(32'd16); send(32'd32); send(32'd48);
    check("basic_valid", 64'(valid_a), 64'd1);
    check("basic_int",   64'(int_a),   sc(64'd96));
    cyc();
    check("basic_done",  64'(valid_a), 64'd0);
    check("basic_keep",  64'(int_a),   sc(64'd96));

    // gapped input with backpressure, surf_valid during HOLD dropped
    rdy = 1'b0;
    do_start(16'd4);
    repeat (4) begin send(32'd8); cyc(); end
    repeat (5) send(32'd999);
    check("gap_valid", 64'(valid_a), 64'd1);
    check("gap_busy",  64'(busy_a),  64'd1);
    check("gap_int",   64'(int_a),   sc(64'd32));
    check("gap_cnt",   64'(cnt_a),   64'd4);
    rdy = 1'b1; cyc();
    check("gap_done",  64'(valid_a), 64'd0);

    // zero window
    do_start(16'd0);
    check("zero_valid", 64'(valid_a), 64'd1);
    check("zero_int",   64'(int_a),   64'd0);
    check("zero_ovf",   64'(ovf_a),   64'd0);
    cyc();

    // overflow on the 33-bit instance
    do_start(16'd2);
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFF);
    check("ov2_int33", 64'(int_b), sc(64'h1_FFFF_FFFE));
    check("ov2_ovf33", 64'(ovf_b), 64'd0);
    cyc();
    do_start(16'd3);
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF);
    check("ov3_int33", 64'(int_b), sc(64'h0_FFFF_FFFD));
    check("ov3_ovf33", 64'(ovf_b), 64'd1);
    check("ov3_int48", 64'(int_a), sc(64'h2_FFFF_FFFD));
    check("ov3_ovf48", 64'(ovf_a), 64'd0);
    cyc();
    do_start(16'd1);
    check("ov_clear", 64'(ovf_b), 64'd0);
    send(32'd1); cyc();

    // reset mid-window
    do_start(16'd5);
    send(32'd10); send(32'd20);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_cnt",  64'(cnt_a),  64'd0);
    check("rst_int",  64'(int_a),  64'd0);
    repeat (3) send(32'd7);
    do_start(16'd1);
    send(32'd64);
    check("rst_new_int", 64'(int_a), sc(64'd64));
    cyc();

    // start ignored in ACCUM and HOLD
    rdy = 1'b0;
    do_start(16'd2);
    start = 1'b1; win_len = 16'd7;
    send(32'd5); send(32'd6);
    repeat (3) cyc();
    check("ign_int", 64'(int_a), sc(64'd11));
    check("ign_cnt", 64'(cnt_a), 64'd2);
    start = 1'b0;
    rdy = 1'b1; cyc();
    repeat (4) send(32'd3);
    check("ign_no_second", 64'(valid_a), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      win_len    = 16'($urandom_range(0, 6));
      surf_valid = $urandom_range(0, 1);
      surf_in    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rdy        = $urandom_range(0, 1);
      rst        = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; start = 1'b0; surf_valid = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
